// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - framing constants and checksum shared by spi_listener and spi_reporter
package spi_frame_pkg;

  localparam logic [7:0] HEADER_DEF    = 8'hA2;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;
  localparam int         FRAME_LEN     = 5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_B2   = 3'd2;
  localparam logic [2:0] ST_B1   = 3'd3;
  localparam logic [2:0] ST_B0   = 3'd4;
  localparam logic [2:0] ST_CSUM = 3'd5;

  typedef struct packed {
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] b0;
  } report_word_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] hdr, input report_word_t w);
    return hdr ^ w.b2 ^ w.b1 ^ w.b0;
  endfunction

endpackage

// File: rtl/spi_reporter_if.sv
// rtl/spi_reporter_if.sv - report input handshake and SPI slave byte side of spi_reporter
interface spi_reporter_if;

  logic [23:0] report_data;
  logic        report_valid;
  logic        report_ready;
  logic        spi_slave_tx_req;
  logic [7:0]  spi_slave_tx_byte;
  logic        spi_reporter_busy;
  logic        spi_reporter_done;
  logic        spi_reporter_abort;
  logic [15:0] timeout_cnt;

  modport master (
    output report_data, report_valid, spi_slave_tx_req,
    input  report_ready, spi_slave_tx_byte, spi_reporter_busy,
    input  spi_reporter_done, spi_reporter_abort, timeout_cnt
  );

  modport slave (
    input  report_data, report_valid, spi_slave_tx_req,
    output report_ready, spi_slave_tx_byte, spi_reporter_busy,
    output spi_reporter_done, spi_reporter_abort, timeout_cnt
  );

endinterface

// File: rtl/spi_reporter_buf.sv
// rtl/spi_reporter_buf.sv - one-deep report word holding register with valid/ready input
module spi_reporter_buf
  import spi_frame_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [23:0]  i_data,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_pop,
  output logic         o_full,
  output report_word_t o_word
);

  logic         r_full;
  report_word_t r_word;

  // A pop only happens while full, so ready is already low and no accept can collide with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_word <= '0;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end else if (i_valid && !r_full) begin
      r_full <= 1'b1;
      r_word <= i_data;
    end
  end

  assign o_ready = !r_full;
  assign o_full  = r_full;
  assign o_word  = r_word;

endmodule

// File: rtl/spi_reporter.sv
// rtl/spi_reporter.sv - frames 24-bit report words as HDR/B2/B1/B0/CSUM bytes for an SPI slave MISO path
module spi_reporter
  import spi_frame_pkg::*;
#(
  parameter logic [7:0] HEADER    = HEADER_DEF,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF,
  parameter int         TIMEOUT   = 1000
) (
  input logic           clk,
  input logic           rst,
  spi_reporter_if.slave bus
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("spi_reporter: TIMEOUT out of range");
  end

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  logic [2:0]   r_state;
  logic [7:0]   r_b2;
  logic [7:0]   r_b1;
  logic [7:0]   r_b0;
  logic [7:0]   r_csum;
  logic [7:0]   r_tx_byte;
  logic         r_done;
  logic         r_abort;
  logic [15:0]  r_tcnt;

  logic         w_full;
  logic         w_pop;
  logic         w_req;
  logic         w_timeout;
  logic [7:0]   w_state_byte;
  report_word_t w_word;

  spi_reporter_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_data  (bus.report_data),
    .i_valid (bus.report_valid),
    .o_ready (bus.report_ready),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_word  (w_word)
  );

  assign w_req     = bus.spi_slave_tx_req;
  assign w_pop     = (r_state == ST_IDLE) && w_full;
  // A request on the last allowed cycle wins over the timeout.
  assign w_timeout = (r_state != ST_IDLE) && !w_req && (r_tcnt == TIMEOUT_M1);

  always_comb begin
    w_state_byte = IDLE_BYTE;
    case (r_state)
      ST_HDR:  w_state_byte = HEADER;
      ST_B2:   w_state_byte = r_b2;
      ST_B1:   w_state_byte = r_b1;
      ST_B0:   w_state_byte = r_b0;
      ST_CSUM: w_state_byte = r_csum;
      default: w_state_byte = IDLE_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_b2      <= '0;
      r_b1      <= '0;
      r_b0      <= '0;
      r_csum    <= '0;
      r_tx_byte <= IDLE_BYTE;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_tx_byte <= w_state_byte;

      if (r_state == ST_IDLE || w_req || w_timeout) r_tcnt <= '0;
      else                                          r_tcnt <= r_tcnt + 16'd1;

      if (r_state == ST_IDLE) begin
        if (w_full) begin
          r_b2    <= w_word.b2;
          r_b1    <= w_word.b1;
          r_b0    <= w_word.b0;
          r_csum  <= frame_csum(HEADER, w_word);
          r_state <= ST_HDR;
        end
      end else if (w_timeout) begin
        r_abort <= 1'b1;
        r_state <= ST_IDLE;
      end else if (w_req) begin
        case (r_state)
          ST_HDR:  r_state <= ST_B2;
          ST_B2:   r_state <= ST_B1;
          ST_B1:   r_state <= ST_B0;
          ST_B0:   r_state <= ST_CSUM;
          default: begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.spi_slave_tx_byte  = r_tx_byte;
  assign bus.spi_reporter_busy  = (r_state != ST_IDLE);
  assign bus.spi_reporter_done  = r_done;
  assign bus.spi_reporter_abort = r_abort;
  assign bus.timeout_cnt        = r_tcnt;

endmodule
